// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// handshake state encoding and the bridge slot this block occupies.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_MASK  = 2'd0;
    localparam logic [1:0] IRQ_MODE  = 2'd1;
    localparam logic [1:0] IRQ_PEND  = 2'd2;
    localparam logic [1:0] IRQ_CLAIM = 2'd3;

    localparam logic [31:0] IRQ_SLOT_BASE = 32'h0000_7F40;

    localparam int CLAIM_ID_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Claim register layout: valid flag in bit 31, source id in the low bits.
    function automatic logic [31:0] claimWord(input logic valid, input logic [CLAIM_ID_W-1:0] id);
        return {valid, {(31-CLAIM_ID_W){1'b0}}, id};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: bit 0 of the request vector wins.
module irq_prio_enc #(
    parameter int N    = 6,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    i_req,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: pending/mask/mode registers, fixed-priority
// selection and a claim/EOI handshake driving a one-hot HWInt request.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int               N_SRC    = 6,
    parameter logic [N_SRC-1:0] RST_MASK = '0,
    parameter logic [N_SRC-1:0] RST_MODE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [1:0]       Addr,
    input  logic             WE,
    input  logic             RE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    output logic [N_SRC-1:0] HWInt
);

    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_mode;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_srcQ;
    logic [N_SRC-1:0] r_hwInt;
    logic [ID_W-1:0]  r_winId;
    irq_state_t       r_state;

    logic [N_SRC-1:0] w_edgeHit;
    logic [N_SRC-1:0] w_pendNow;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_claimClr;
    logic [N_SRC-1:0] w_pendNext;
    logic             w_encValid;
    logic [ID_W-1:0]  w_encId;
    logic [ID_W-1:0]  w_winNext;
    logic             w_claim;
    irq_state_t       w_stateNext;
    logic             w_unusedDin;

    assign w_unusedDin = ^Din[31:N_SRC];

    // Edge bits live in r_pend; level bits follow the sampled line directly.
    // r_pend is forced to 0 for level bits, so switching level->edge starts clear.
    assign w_edgeHit  = src_irq & ~r_srcQ;
    assign w_pendNow  = (r_mode & r_pend) | (~r_mode & r_srcQ);
    assign w_eligible = w_pendNow & r_mask;
    assign w_w1c      = (WE && Addr == IRQ_PEND) ? Din[N_SRC-1:0] : '0;
    assign w_claimClr = w_claim ? (N_SRC'(1) << r_winId) : '0;
    assign w_pendNext = r_mode & (w_edgeHit | (r_pend & ~(w_w1c | w_claimClr)));

    irq_prio_enc #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_prioEnc (
        .i_req   (w_eligible),
        .o_valid (w_encValid),
        .o_id    (w_encId)
    );

    always_comb begin
        w_stateNext = r_state;
        w_winNext   = r_winId;
        w_claim     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_encValid) begin
                    w_stateNext = ASSERT;
                    w_winNext   = w_encId;
                end
            end
            ASSERT: begin
                if (RE && Addr == IRQ_CLAIM) begin
                    w_claim     = 1'b1;
                    w_stateNext = SERVICE;
                end else if (!w_eligible[r_winId]) begin
                    w_stateNext = IDLE;
                end else begin
                    w_winNext = w_encId;
                end
            end
            SERVICE: begin
                if (WE && Addr == IRQ_CLAIM) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // HWInt is registered from the next state so it tracks ASSERT exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask  <= RST_MASK;
            r_mode  <= RST_MODE;
            r_pend  <= '0;
            r_srcQ  <= '0;
            r_state <= IDLE;
            r_winId <= '0;
            r_hwInt <= '0;
        end else begin
            r_srcQ  <= src_irq;
            r_pend  <= w_pendNext;
            r_state <= w_stateNext;
            r_winId <= w_winNext;
            r_hwInt <= (w_stateNext == ASSERT) ? (N_SRC'(1) << w_winNext) : '0;
            if (WE && Addr == IRQ_MASK) begin
                r_mask <= Din[N_SRC-1:0];
            end
            if (WE && Addr == IRQ_MODE) begin
                r_mode <= Din[N_SRC-1:0];
            end
        end
    end

    always_comb begin
        Dout = '0;
        unique case (Addr)
            IRQ_MASK:  Dout[N_SRC-1:0] = r_mask;
            IRQ_MODE:  Dout[N_SRC-1:0] = r_mode;
            IRQ_PEND:  Dout[N_SRC-1:0] = w_pendNow;
            IRQ_CLAIM: begin
                if (r_state == ASSERT) begin
                    Dout = claimWord(1'b1, CLAIM_ID_W'(r_winId));
                end
            end
            default:   Dout = '0;
        endcase
    end

    assign HWInt = r_hwInt;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed handshake scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [5:0]  src_irq;
    logic [1:0]  Addr;
    logic        WE;
    logic        RE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  HWInt;

    int checkCount;
    int failCount;

    // Model: phase 0 = nothing requested, 1 = requesting CPU, 2 = being serviced.
    bit [5:0] mMask;
    bit [5:0] mMode;
    bit [5:0] mPendEdge;
    bit [5:0] mPrev;
    int       mPhase;
    int       mCur;

    irq_ctrl #(
        .N_SRC    (6),
        .RST_MASK (6'b000000),
        .RST_MODE (6'b000000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .Addr    (Addr),
        .WE      (WE),
        .RE      (RE),
        .Din     (Din),
        .Dout    (Dout),
        .HWInt   (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [5:0] modelPend();
        bit [5:0] p;
        for (int i = 0; i < 6; i++) begin
            p[i] = mMode[i] ? mPendEdge[i] : mPrev[i];
        end
        return p;
    endfunction

    function automatic int lowestSet(input bit [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] modelDout(input logic [1:0] a);
        case (a)
            2'd0:    return {26'b0, mMask};
            2'd1:    return {26'b0, mMode};
            2'd2:    return {26'b0, modelPend()};
            default: return (mPhase == 1) ? (32'h8000_0000 | 32'(mCur)) : 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] modelHw();
        return (mPhase == 1) ? (32'd1 << mCur) : 32'd0;
    endfunction

    task automatic modelReset();
        mMask     = 6'b000000;
        mMode     = 6'b000000;
        mPendEdge = '0;
        mPrev     = '0;
        mPhase    = 0;
        mCur      = 0;
    endtask

    task automatic modelStep(input bit [5:0] src, input bit [1:0] a, input bit we, input bit re, input bit [31:0] din);
        bit [5:0] elig;
        bit [5:0] nextPend;
        int       claimed;
        bit       hit;
        bit       clr;
        elig    = modelPend() & mMask;
        claimed = -1;
        if (mPhase == 0) begin
            if (elig != 0) begin
                mPhase = 1;
                mCur   = lowestSet(elig);
            end
        end else if (mPhase == 1) begin
            if (re && a == 2'd3) begin
                claimed = mCur;
                mPhase  = 2;
            end else if (!elig[mCur]) begin
                mPhase = 0;
            end else begin
                mCur = lowestSet(elig);
            end
        end else begin
            if (we && a == 2'd3) mPhase = 0;
        end
        for (int i = 0; i < 6; i++) begin
            hit = src[i] && !mPrev[i];
            clr = (we && a == 2'd2 && din[i]) || (claimed == i);
            nextPend[i] = mMode[i] ? (hit || (mPendEdge[i] && !clr)) : 1'b0;
        end
        mPendEdge = nextPend;
        mPrev     = src;
        if (we && a == 2'd0) mMask = din[5:0];
        if (we && a == 2'd1) mMode = din[5:0];
    endtask

    // One bus cycle: drive at negedge, compare just after, advance model at posedge.
    task automatic applyStimulus(input logic [5:0] src, input logic [1:0] a, input logic we, input logic re, input logic [31:0] din);
        src_irq = src;
        Addr    = a;
        WE      = we;
        RE      = re;
        Din     = din;
        #1;
        checkOutput("dout", Dout, modelDout(a));
        checkOutput("hwint", {26'b0, HWInt}, modelHw());
        @(posedge clk);
        modelStep(src, a, we, re, din);
        @(negedge clk);
    endtask

    task automatic doReset();
        reset   = 1'b1;
        src_irq = '0;
        Addr    = '0;
        WE      = 1'b0;
        RE      = 1'b0;
        Din     = '0;
        @(posedge clk);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        WE   = 1'b0;
        RE   = 1'b0;
        #1;
        checkOutput(tag, Dout, exp);
    endtask

    initial begin
        logic [5:0] srcState;
        checkCount = 0;
        failCount  = 0;
        reset   = 1'b1;
        src_irq = '0;
        Addr    = '0;
        WE      = 1'b0;
        RE      = 1'b0;
        Din     = '0;
        $display("[TB] irq_ctrl slot base 0x%08h", IRQ_SLOT_BASE);
        @(negedge clk);
        doReset();

        peek("rst_mask", IRQ_MASK, 32'h0);
        peek("rst_mode", IRQ_MODE, 32'h0);
        peek("rst_pend", IRQ_PEND, 32'h0);
        peek("rst_claim", IRQ_CLAIM, 32'h0);
        checkOutput("rst_hwint", {26'b0, HWInt}, 32'h0);

        // Edge source 0: pulse, claim, EOI.
        applyStimulus(6'h00, IRQ_MASK, 1, 0, 32'h3F);
        applyStimulus(6'h00, IRQ_MODE, 1, 0, 32'h01);
        applyStimulus(6'h01, IRQ_PEND, 0, 0, 0);
        applyStimulus(6'h00, IRQ_PEND, 0, 0, 0);
        checkOutput("edge_hwint", {26'b0, HWInt}, 32'h01);
        peek("edge_claim", IRQ_CLAIM, 32'h8000_0000);
        applyStimulus(6'h00, IRQ_CLAIM, 0, 1, 0);
        peek("edge_pend_clr", IRQ_PEND, 32'h0);
        applyStimulus(6'h00, IRQ_CLAIM, 1, 0, 0);
        applyStimulus(6'h00, IRQ_PEND, 0, 0, 0);
        checkOutput("edge_eoi_hwint", {26'b0, HWInt}, 32'h0);

        // Two level sources: priority, then the lower one after EOI.
        doReset();
        applyStimulus(6'h00, IRQ_MASK, 1, 0, 32'h3F);
        applyStimulus(6'h06, IRQ_PEND, 0, 0, 0);
        applyStimulus(6'h06, IRQ_PEND, 0, 0, 0);
        checkOutput("lvl_hwint1", {26'b0, HWInt}, 32'h02);
        peek("lvl_claim", IRQ_CLAIM, 32'h8000_0001);
        applyStimulus(6'h06, IRQ_CLAIM, 0, 1, 0);
        applyStimulus(6'h04, IRQ_CLAIM, 1, 0, 0);
        applyStimulus(6'h04, IRQ_PEND, 0, 0, 0);
        checkOutput("lvl_hwint2", {26'b0, HWInt}, 32'h04);

        // Pending but masked, then unmasked.
        doReset();
        applyStimulus(6'h00, IRQ_MODE, 1, 0, 32'h3F);
        applyStimulus(6'h08, IRQ_PEND, 0, 0, 0);
        applyStimulus(6'h00, IRQ_PEND, 0, 0, 0);
        peek("mask_pend", IRQ_PEND, 32'h08);
        checkOutput("mask_hwint0", {26'b0, HWInt}, 32'h0);
        applyStimulus(6'h00, IRQ_MASK, 1, 0, 32'h08);
        applyStimulus(6'h00, IRQ_PEND, 0, 0, 0);
        checkOutput("mask_hwint1", {26'b0, HWInt}, 32'h08);

        // W1C colliding with a fresh edge: the set wins.
        doReset();
        applyStimulus(6'h00, IRQ_MODE, 1, 0, 32'h3F);
        applyStimulus(6'h10, IRQ_PEND, 0, 0, 0);
        applyStimulus(6'h00, IRQ_PEND, 0, 0, 0);
        applyStimulus(6'h10, IRQ_PEND, 1, 0, 32'h10);
        peek("w1c_setwins", IRQ_PEND, 32'h10);

        // No nesting during service; reset mid-request.
        doReset();
        applyStimulus(6'h00, IRQ_MASK, 1, 0, 32'h3F);
        applyStimulus(6'h00, IRQ_MODE, 1, 0, 32'h3F);
        applyStimulus(6'h04, IRQ_PEND, 0, 0, 0);
        applyStimulus(6'h00, IRQ_PEND, 0, 0, 0);
        applyStimulus(6'h00, IRQ_CLAIM, 0, 1, 0);
        applyStimulus(6'h01, IRQ_PEND, 0, 0, 0);
        applyStimulus(6'h00, IRQ_PEND, 0, 0, 0);
        checkOutput("svc_nopreempt", {26'b0, HWInt}, 32'h0);
        applyStimulus(6'h00, IRQ_CLAIM, 1, 0, 0);
        applyStimulus(6'h00, IRQ_PEND, 0, 0, 0);
        checkOutput("svc_after_eoi", {26'b0, HWInt}, 32'h01);
        doReset();
        checkOutput("rst_mid_hwint", {26'b0, HWInt}, 32'h0);
        peek("rst_mid_pend", IRQ_PEND, 32'h0);

        // Randomized traffic against the model.
        srcState = '0;
        for (int n = 0; n < 3000; n++) begin
            logic [1:0]  a;
            logic        we;
            logic        re;
            logic [31:0] din;
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 5) == 0) srcState[b] = ~srcState[b];
            end
            a   = 2'($urandom_range(0, 3));
            we  = ($urandom_range(0, 5) == 0);
            re  = ($urandom_range(0, 2) == 0);
            din = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                doReset();
            end else begin
                applyStimulus(srcState, a, we, re, din);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller between the peripheral IRQ lines (timer, UART, keys, spares) and the CPU HWInt[7:2] inputs.
- Latches per-source pending bits, applies a mask and an edge/level mode, and picks one winner by fixed priority.
- Drives a one-hot request to the CPU and sequences a claim/EOI handshake through a bridge-mapped register window.
- Sits behind the system bridge as another peripheral slot; replaces the direct IRQ-to-HWInt concatenation.

Parameters:
- N_SRC, 6, number of interrupt sources (HWInt[7:2] width).
- RST_MASK, 6'b000000, mask register value after reset.
- RST_MODE, 6'b000000, mode register value after reset (1 = edge, 0 = level).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- src_irq  in  N_SRC  raw peripheral IRQ lines; bit 0 is the highest priority.
- Addr  in  2  bridge word address bits [3:2].
- WE  in  1  register write strobe, one cycle.
- RE  in  1  register read strobe, one cycle; qualifies claim side effects.
- Din  in  32  write data.
- Dout  out  32  read data, combinational from Addr.
- HWInt  out  N_SRC  one-hot interrupt request to CPU CP0.

Behaviour:
- Register map:
  - 0x0 MASK, RW, bits[N_SRC-1:0].
  - 0x4 MODE, RW.
  - 0x8 PEND, read pending; write-1-to-clear edge bits.
  - 0xC CLAIM: read returns {valid[31], 26'b0, id[4:0]}; any write is EOI.
  - Unused Dout bits read 0.
- src_q <= src_irq every cycle. edge_hit = src_irq & ~src_q.
- Edge-mode pending bit:
  - Set on edge_hit.
  - Cleared by PEND W1C, or by a claim of that source.
  - Set wins over clear in the same cycle.
- Level-mode pending bit: pend = src_q, live. W1C and claim have no effect on it.
- eligible = pend & MASK. Winner = lowest-index set bit of eligible.
- FSM states IDLE, ASSERT, SERVICE:
  - IDLE -> ASSERT when eligible != 0. Latch win_id.
  - ASSERT -> SERVICE on RE with Addr == 3 (claim). Claim read returns valid = 1, id = win_id. Edge pending[win_id] clears at that edge.
  - ASSERT -> IDLE if eligible[win_id] drops before the claim (mask cleared or level source released). Spurious request withdrawn.
  - SERVICE -> IDLE on WE with Addr == 3 (EOI). EOI in IDLE or ASSERT is ignored.
- Priority re-evaluation: win_id is re-latched every cycle in ASSERT, so a higher-priority arrival pre-empts before the claim. In SERVICE there is no pre-emption (non-nested).
- HWInt:
  - One-hot of win_id while the state is ASSERT (registered output); 0 otherwise.
  - Latency: source rises before edge E0 -> pending visible after E0 -> ASSERT after E1 -> HWInt high in cycle after E1.
- Claim read outside ASSERT: returns valid = 0, id = 0, no state change.
- reset:
  - MASK = RST_MASK, MODE = RST_MODE.
  - pend = 0, src_q = 0, state = IDLE, win_id = 0, HWInt = 0.
  - Applies mid-handshake; a pending claim is discarded.
- A MODE change from level to edge clears that bit's pending in the same cycle.

Decomposition:
- Shared package holds:
  - Register offsets IRQ_MASK = 2'd0, IRQ_MODE = 2'd1, IRQ_PEND = 2'd2, IRQ_CLAIM = 2'd3.
  - State encoding IDLE / ASSERT / SERVICE.
  - Bridge slot address constant for this block.
- One sub-module: irq_prio_enc, a combinational lowest-index priority encoder (N_SRC -> {valid, id}). All state stays in irq_ctrl.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC -> 0, 0, 0, 0x00000000; HWInt = 0.
- MASK = 6'h3F, MODE = 6'h01, pulse src_irq[0] for one cycle -> HWInt = 6'b000001 two cycles later. Claim read -> 0x80000000, PEND bit0 = 0. EOI -> IDLE, HWInt stays 0.
- MASK = 6'h3F, level src_irq[2] and src_irq[1] both high -> HWInt = 6'b000010, claim id = 1. Drop src_irq[1], EOI -> HWInt = 6'b000100 two cycles later.
- Pending masked bit: MASK = 0, MODE = 6'h3F, pulse src_irq[3] -> PEND = 0x8, HWInt = 0. Write MASK = 0x8 -> HWInt = 6'b001000.
- Simultaneous W1C of PEND bit4 and a new edge on src_irq[4] -> PEND bit4 remains 1.
- In SERVICE for id 2, a higher-priority edge on src 0 -> HWInt stays 0 until EOI, then HWInt = 6'b000001. Assert reset mid-ASSERT -> HWInt = 0 next cycle, PEND = 0.
